seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 22 ++
 rtl/seq_alu_mul.sv | 64 ++++++
 rtl/seq_alu.sv | 168 ++++++++++++++++
 tb/tb_seq_alu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: default width, opcode encodings and FSM state encoding.
package seq_alu_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [3:0] OpAddc = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0011;
  localparam logic [3:0] OpNand = 4'b0100;
  localparam logic [3:0] OpOr   = 4'b0101;
  localparam logic [3:0] OpXor  = 4'b0110;
  localparam logic [3:0] OpNot  = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1000;
  localparam logic [3:0] OpMul  = 4'b1001;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles in total.
// The first partial product is folded into the start cycle so done_o pulses WIDTH-1 cycles later.
module seq_alu_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start_i) begin
      acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
      mcand_d  = {{(WIDTH - 1){1'b0}}, a_i, 1'b0};
      mplier_d = b_i >> 1;
      cnt_d    = CntW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
      done_d   = (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered results; single-cycle ops, optional multi-cycle MUL.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier; otherwise opcode 1001 is illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] aluin_a,
  input  logic [WIDTH-1:0] aluin_b,
  input  logic [3:0]       OPCODE,
  input  logic             Cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             Cout,
  output logic             OF,
  output logic             Z,
  output logic             ILL,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned ShW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
  logic             cout_q, cout_d, of_q, of_d, z_q, z_d, ill_q, ill_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_cout, res_of, res_ill;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul    = (OPCODE == OpMul);
  assign mul_start = accept && is_mul;

  seq_alu_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (mul_start),
    .a_i       (aluin_a),
    .b_i       (aluin_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle datapath; undefined opcodes leave res at zero.
  always_comb begin
    sum      = '0;
    res      = '0;
    res_cout = 1'b0;
    res_of   = 1'b0;
    res_ill  = 1'b0;
    case (OPCODE)
      OpAddc, OpAdd: begin
        sum      = {1'b0, aluin_a} + {1'b0, aluin_b} +
                   {{WIDTH{1'b0}}, (OPCODE == OpAddc) & Cin};
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_of   = (aluin_a[WIDTH-1] == aluin_b[WIDTH-1]) && (res[WIDTH-1] != aluin_a[WIDTH-1]);
      end
      OpSub: begin
        sum      = {1'b0, aluin_a} + {1'b0, ~aluin_b} + {{WIDTH{1'b0}}, 1'b1};
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_of   = (aluin_a[WIDTH-1] != aluin_b[WIDTH-1]) && (res[WIDTH-1] != aluin_a[WIDTH-1]);
      end
      OpNand:  res = ~(aluin_a & aluin_b);
      OpOr:    res = aluin_a | aluin_b;
      OpXor:   res = aluin_a ^ aluin_b;
      OpNot:   res = ~aluin_a;
      OpSrl:   res = aluin_a >> aluin_b[ShW-1:0];
      default: res_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    cout_d  = cout_q;
    of_d    = of_q;
    z_d     = z_q;
    ill_d   = ill_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d = StBusy;
          end else begin
            out_d   = res;
            hi_d    = '0;
            cout_d  = res_cout;
            of_d    = res_of;
            z_d     = (res == '0);
            ill_d   = res_ill;
            state_d = StDone;
          end
        end
      end
`ifdef SEQ_ALU_MUL_EN
      StBusy: begin
        if (mul_done) begin
          out_d   = mul_prod[WIDTH-1:0];
          hi_d    = mul_prod[2*WIDTH-1:WIDTH];
          cout_d  = (mul_prod[2*WIDTH-1:WIDTH] != '0);
          of_d    = 1'b0;
          z_d     = (mul_prod == '0);
          ill_d   = 1'b0;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      out_q   <= '0;
      hi_q    <= '0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
      z_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      cout_q  <= cout_d;
      of_q    <= of_d;
      z_q     <= z_d;
      ill_q   <= ill_d;
    end
  end

  assign alu_out = out_q;
  assign alu_hi  = hi_q;
  assign Cout    = cout_q;
  assign OF      = of_q;
  assign Z       = z_q;
  assign ILL     = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): driver pushes model results, monitor pops on out_valid.
module tb_seq_alu;

  localparam int unsigned W = 8;
  localparam longint Full = 64'd1 << W;
  localparam longint Mask = Full - 1;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] aluin_a, aluin_b;
  logic [3:0]   OPCODE;
  logic         Cin, in_valid, in_ready;
  logic [W-1:0] alu_out, alu_hi;
  logic         Cout, OF, Z, ILL, out_valid, out_ready;

  seq_alu #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .aluin_a   (aluin_a),
    .aluin_b   (aluin_b),
    .OPCODE    (OPCODE),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_hi    (alu_hi),
    .Cout      (Cout),
    .OF        (OF),
    .Z         (Z),
    .ILL       (ILL),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint out;
    longint hi;
    bit     cout;
    bit     of;
    bit     z;
    bit     ill;
    int     lat;
    int     acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: always high, 2: random
  bit   ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v >= Full / 2) ? v - Full : v;
  endfunction

  // Reference behaviour straight from the opcode table, using plain integer arithmetic.
  function automatic exp_t model(input longint a, input longint b, input int op, input int cin);
    exp_t   e;
    longint p, s;
    e = '{default: 0};
    e.lat = 1;
    case (op)
      1, 2: begin
        p = a + b + ((op == 1) ? cin : 0);
        s = sgn(a) + sgn(b) + ((op == 1) ? cin : 0);
        e.out  = p & Mask;
        e.cout = (p >= Full);
        e.of   = (s >= Full / 2) || (s < -(Full / 2));
      end
      3: begin
        s = sgn(a) - sgn(b);
        e.out  = (a - b) & Mask;
        e.cout = (a >= b);
        e.of   = (s >= Full / 2) || (s < -(Full / 2));
      end
      4: e.out = ~(a & b) & Mask;
      5: e.out = a | b;
      6: e.out = a ^ b;
      7: e.out = ~a & Mask;
      8: e.out = a >> (b % W);
      9: begin
        if (MulEn) begin
          p = a * b;
          e.out  = p & Mask;
          e.hi   = p >> W;
          e.cout = (e.hi != 0);
          e.lat  = W + 1;
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.out == 0) && (e.hi == 0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with inputs scrambled.
  task automatic issue(input longint a, input longint b, input int op, input int cin);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      return;
    end
    aluin_a  = a[W-1:0];
    aluin_b  = b[W-1:0];
    OPCODE   = op[3:0];
    Cin      = cin[0];
    in_valid = 1'b1;
    e = model(a, b, op, cin);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    aluin_a  = W'($urandom);
    aluin_b  = W'($urandom);
    OPCODE   = 4'($urandom);
    Cin      = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", q.size(), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_alu_out"}, alu_out, 0);
    chk({tag, "_alu_hi"}, alu_hi, 0);
    chk({tag, "_cout"}, Cout, 0);
    chk({tag, "_of"}, OF, 0);
    chk({tag, "_z"}, Z, 0);
    chk({tag, "_ill"}, ILL, 0);
  endtask

  // Monitor: owns out_ready, compares every valid cycle so held outputs are checked too.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) out_ready = 1'b0;
      else if (rdy_mode == 1) out_ready = 1'b1;
      else out_ready = ($urandom_range(3) != 0);
      if (!reset) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
          end else begin
            if (!ov_prev) chk("latency", cyc - q[0].acc + 1, q[0].lat);
            chk("alu_out", alu_out, q[0].out);
            chk("alu_hi", alu_hi, q[0].hi);
            chk("cout", Cout, q[0].cout);
            chk("of", OF, q[0].of);
            chk("z", Z, q[0].z);
            chk("ill", ILL, q[0].ill);
            chk("in_ready_in_done", in_ready, 0);
            if (out_ready) void'(q.pop_front());
          end
        end else if (q.size() != 0 && cyc >= q[0].acc) begin
          chk("in_ready_in_busy", in_ready, 0);
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    aluin_a  = '0;
    aluin_b  = '0;
    OPCODE   = '0;
    Cin      = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    // Directed corner cases
    issue(64'h7F, 64'h01, 2, 0);
    issue(64'h07, 64'h06, 3, 0);
    issue(64'hFF, 64'h01, 2, 0);
    issue(64'h7F, 64'h00, 1, 1);
    issue(64'hFF, 64'hFF, 1, 1);
    issue(64'h00, 64'h01, 3, 0);
    issue(64'h80, 64'h01, 3, 0);
    issue(64'hFF, 64'hFF, 4, 0);
    issue(64'hA0, 64'h05, 5, 0);
    issue(64'h3C, 64'h3C, 6, 0);
    issue(64'h5A, 64'h00, 7, 0);
    issue(64'hA5, 64'h00, 8, 0);
    issue(64'h80, 64'h07, 8, 0);
    issue(64'hF0, 64'hFB, 8, 0);
    issue(64'hFF, 64'hFF, 9, 0);
    issue(64'h00, 64'h37, 9, 0);
    issue(64'h12, 64'h34, 0, 1);
    issue(64'hAB, 64'hCD, 15, 0);
    drain();

    // Hold response for 5 cycles while hammering the inputs
    rdy_mode = 0;
    issue(64'h3C, 64'h0F, 6, 0);
    repeat (5) begin
      aluin_a  = W'($urandom);
      aluin_b  = W'($urandom);
      OPCODE   = 4'($urandom_range(1, 8));
      in_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    drain();

    // Reset during BUSY (MUL) or DONE (MUL treated as illegal) abandons the operation
    rdy_mode = 0;
    issue(64'hFF, 64'hFF, 9, 0);
    if (MulEn) repeat (3) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    check_idle_zero("mid_reset");
    reset    = 1'b0;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    chk("no_resp_after_reset", out_valid, 0);

    // Reset wins over a simultaneous acceptance
    reset    = 1'b1;
    in_valid = 1'b1;
    aluin_a  = 8'h01;
    aluin_b  = 8'h01;
    OPCODE   = 4'd2;
    @(negedge clk);
    check_idle_zero("reset_vs_accept");
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_resp_after_reset_accept", out_valid, 0);

    // Randomised traffic with random backpressure
    rdy_mode = 2;
    repeat (300) begin
      issue(longint'($urandom_range(255)), longint'($urandom_range(255)),
            int'($urandom_range(15)), int'($urandom_range(1)));
    end
    rdy_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
